// File: rtl/mdr_fetch_unit.sv
// mdr_fetch_unit
//   Memory-read sequencer and Memory Data Register for the multicycle
//   datapath. A read request accepted in IDLE issues one read strobe to the
//   synchronous data memory, waits MEM_LATENCY cycles, then captures the
//   returned word shifted right so the addressed byte/halfword lands at
//   bit 0. Misaligned or illegal-size requests are rejected with a single
//   align_err pulse and never reach memory.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   rd_req     read request, sampled only in IDLE
//   rd_addr    byte address of the load
//   ls_size    01 word, 11 halfword, 10 byte, 00 illegal
//   busy       high whenever the sequencer is not IDLE
//   mem_rd     one-cycle read strobe to data memory
//   mem_addr   word address to memory, held outside the strobe cycle
//   mem_rdata  memory read data, little-endian byte lanes
//   MDR_out    aligned load data, held until the next capture
//   mdr_valid  one-cycle pulse in the cycle MDR_out has new data
//   align_err  one-cycle pulse for a rejected request
module mdr_fetch_unit #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic [1:0]  ls_size,
    output logic        busy,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [31:0] MDR_out,
    output logic        mdr_valid,
    output logic        align_err
);

    localparam int unsigned CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("mdr_fetch_unit: MEM_LATENCY must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERR
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      lane_q;
    logic            req_illegal;
    logic            accept;
    logic            wait_done;

    // Only the byte-lane bits of the address are needed after acceptance;
    // the word part goes straight into mem_addr, and size only matters for
    // the legality check made at acceptance time.
    always_comb begin
        req_illegal = 1'b0;
        unique case (ls_size)
            2'b00: req_illegal = 1'b1;
            2'b01: req_illegal = (rd_addr[1:0] != 2'b00);
            2'b11: req_illegal = rd_addr[0];
            default: req_illegal = 1'b0;
        endcase
    end

    assign accept    = (state == IDLE) && rd_req;
    assign wait_done = (state == WAIT) && (cnt_q == LAT);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (rd_req) begin
                    state_nx = req_illegal ? ERR : ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (cnt_q == LAT) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            ERR: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_rd    = (state == ISSUE);
        mdr_valid = (state == DONE);
        align_err = (state == ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt_q    <= '0;
            lane_q   <= '0;
            mem_addr <= '0;
            MDR_out  <= '0;
        end else begin
            state <= state_nx;
            // mem_addr is loaded as the request is accepted so it is already
            // valid during the ISSUE strobe, and is left alone otherwise.
            if (accept && !req_illegal) begin
                mem_addr <= {rd_addr[31:2], 2'b00};
                lane_q   <= rd_addr[1:0];
            end
            if (state == ISSUE) begin
                cnt_q <= CW'(1);
            end else if ((state == WAIT) && !wait_done) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (wait_done) begin
                MDR_out <= mem_rdata >> {lane_q, 3'b000};
            end
        end
    end

endmodule

// File: tb/tb_mdr_fetch_unit.sv
// Bench for mdr_fetch_unit: two instances (MEM_LATENCY 1 and 3) share one
// request stream; each has its own latency-accurate memory model. A
// schedule-based reference model predicts every output on every cycle, and
// directed literal checks pin the expected values of the test plan.
module tb_mdr_fetch_unit;

    localparam logic [31:0] JUNK = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [1:0]  ls_size = 2'b01;
    logic [31:0] mem_word = '0;

    logic        busy_a, mem_rd_a, mdv_a, aerr_a;
    logic [31:0] mem_addr_a, mem_rdata_a, mdr_a;
    logic        busy_b, mem_rd_b, mdv_b, aerr_b;
    logic [31:0] mem_addr_b, mem_rdata_b, mdr_b;

    logic [2:0]  pipe_a = '0;
    logic [2:0]  pipe_b = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdr_fetch_unit #(.MEM_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
        .ls_size(ls_size), .busy(busy_a), .mem_rd(mem_rd_a),
        .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .MDR_out(mdr_a),
        .mdr_valid(mdv_a), .align_err(aerr_a)
    );

    mdr_fetch_unit #(.MEM_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr),
        .ls_size(ls_size), .busy(busy_b), .mem_rd(mem_rd_b),
        .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .MDR_out(mdr_b),
        .mdr_valid(mdv_b), .align_err(aerr_b)
    );

    // Memory: data is valid only in the cycle exactly MEM_LATENCY after the
    // strobe; any other cycle returns junk so a mistimed capture shows up.
    always @(posedge clk) begin
        pipe_a <= {pipe_a[1:0], mem_rd_a};
        pipe_b <= {pipe_b[1:0], mem_rd_b};
    end
    assign mem_rdata_a = pipe_a[0] ? mem_word : JUNK;
    assign mem_rdata_b = pipe_b[2] ? mem_word : JUNK;

    task automatic chk(input string nm, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %h expected %h", nm, i, $time, got, exp);
        end
    endtask

    // Reference model: each accepted request becomes a schedule relative to
    // its acceptance cycle s: strobe at s+1, result at s+2+L, error at s+1.
    initial begin : model
        int c;
        bit rs;
        bit act [2];
        bit leg [2];
        int start [2];
        logic [31:0] a_l [2];
        logic [31:0] pend [2];
        logic [31:0] e_mdr [2];
        logic [31:0] e_addr [2];
        int d, dur, lat;
        bit eb, er, ev, ee;
        logic [31:0] g_mdr, g_addr;
        logic g_busy, g_rd, g_v, g_e;
        c = 0;
        rs = 1'b1;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; leg[i] = 1'b0; start[i] = 0;
            a_l[i] = '0; pend[i] = '0; e_mdr[i] = '0; e_addr[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                lat = (i == 0) ? 1 : 3;
                eb = 1'b0; er = 1'b0; ev = 1'b0; ee = 1'b0;
                if (rs) begin
                    act[i] = 1'b0;
                    e_mdr[i] = '0;
                    e_addr[i] = '0;
                end else if (act[i]) begin
                    d = c - start[i];
                    dur = leg[i] ? lat + 2 : 1;
                    if (d > dur) begin
                        act[i] = 1'b0;
                    end else if (d >= 1) begin
                        eb = 1'b1;
                        if (leg[i]) begin
                            er = (d == 1);
                            ev = (d == dur);
                            if (d == 1) e_addr[i] = {a_l[i][31:2], 2'b00};
                            if (d == dur) e_mdr[i] = pend[i];
                        end else begin
                            ee = 1'b1;
                        end
                    end
                end
                if (i == 0) begin
                    g_busy = busy_a; g_rd = mem_rd_a; g_v = mdv_a; g_e = aerr_a;
                    g_mdr = mdr_a; g_addr = mem_addr_a;
                end else begin
                    g_busy = busy_b; g_rd = mem_rd_b; g_v = mdv_b; g_e = aerr_b;
                    g_mdr = mdr_b; g_addr = mem_addr_b;
                end
                chk("busy", i, {31'b0, g_busy}, {31'b0, eb});
                chk("mem_rd", i, {31'b0, g_rd}, {31'b0, er});
                chk("mdr_valid", i, {31'b0, g_v}, {31'b0, ev});
                chk("align_err", i, {31'b0, g_e}, {31'b0, ee});
                chk("mem_addr", i, g_addr, e_addr[i]);
                chk("MDR_out", i, g_mdr, e_mdr[i]);
                if (!reset && rd_req && !eb) begin
                    act[i] = 1'b1;
                    start[i] = c;
                    a_l[i] = rd_addr;
                    leg[i] = !((ls_size == 2'b00) ||
                               (ls_size == 2'b01 && rd_addr[1:0] != 2'b00) ||
                               (ls_size == 2'b11 && rd_addr[0]));
                    pend[i] = mem_word >> (8 * rd_addr[1:0]);
                end
            end
            rs = reset;
            c++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((busy_a || busy_b) && n < 30) begin
            tick;
            n++;
        end
        if (busy_a || busy_b) begin
            chk("idle_timeout", 0, {31'b0, busy_a | busy_b}, 32'd0);
        end
    endtask

    task automatic req(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
        wait_idle;
        rd_addr = a;
        ls_size = s;
        mem_word = w;
        rd_req = 1'b1;
        tick;
        rd_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        chk("rst_mdr", 0, mdr_a, 32'h0);
        chk("rst_busy", 1, {31'b0, busy_b}, 32'd0);

        // word read, latency 1: strobe T+1, result T+3
        req(32'h0000_0010, 2'b01, 32'hDEAD_BEEF);
        chk("t1_mem_rd", 0, {31'b0, mem_rd_a}, 32'd1);
        chk("t1_mem_addr", 0, mem_addr_a, 32'h0000_0010);
        tick;
        chk("t1_busy_t2", 0, {31'b0, busy_a}, 32'd1);
        tick;
        chk("t1_valid", 0, {31'b0, mdv_a}, 32'd1);
        chk("t1_mdr", 0, mdr_a, 32'hDEAD_BEEF);
        tick;
        chk("t1_busy_t4", 0, {31'b0, busy_a}, 32'd0);

        // byte lanes
        req(32'h0000_0023, 2'b10, 32'h1122_3344);
        chk("t2_mem_addr", 0, mem_addr_a, 32'h0000_0020);
        wait_idle;
        chk("t2_byte3", 0, mdr_a, 32'h0000_0011);
        chk("t2_byte3", 1, mdr_b, 32'h0000_0011);
        req(32'h0000_0021, 2'b10, 32'h1122_3344);
        wait_idle;
        chk("t2_byte1", 0, mdr_a, 32'h0011_2233);

        // halfword, then misaligned halfword
        req(32'h0000_0042, 2'b11, 32'hCAFE_1234);
        wait_idle;
        chk("t3_half", 1, mdr_b, 32'h0000_CAFE);
        req(32'h0000_0041, 2'b11, 32'h9999_9999);
        chk("t3_aerr", 0, {31'b0, aerr_a}, 32'd1);
        chk("t3_no_rd", 0, {31'b0, mem_rd_a}, 32'd0);
        tick;
        chk("t3_busy1", 0, {31'b0, busy_a}, 32'd0);
        chk("t3_mdr_kept", 0, mdr_a, 32'h0000_CAFE);

        // misaligned word and illegal size
        req(32'h0000_0006, 2'b01, 32'h1234_5678);
        chk("t4_aerr_word", 1, {31'b0, aerr_b}, 32'd1);
        tick;
        chk("t4_busy1", 1, {31'b0, busy_b}, 32'd0);
        req(32'h0000_0008, 2'b00, 32'h1234_5678);
        chk("t4_aerr_size", 0, {31'b0, aerr_a}, 32'd1);
        tick;
        chk("t4_mdr_kept", 1, mdr_b, 32'h0000_CAFE);

        // latency 3 with rd_req held high through the busy window
        wait_idle;
        rd_addr = 32'h0000_0100;
        ls_size = 2'b01;
        mem_word = 32'h0123_4567;
        rd_req = 1'b1;
        n = 0;
        for (int k = 1; k <= 6; k++) begin
            tick;
            n += int'(mem_rd_b);
            if (k == 5) begin
                chk("t5_valid", 1, {31'b0, mdv_b}, 32'd1);
                chk("t5_mdr", 1, mdr_b, 32'h0123_4567);
            end
        end
        chk("t5_one_strobe", 1, n, 32'd1);
        tick;
        rd_req = 1'b0;
        chk("t5_reaccept", 1, {31'b0, mem_rd_b}, 32'd1);

        // reset while waiting on memory
        req(32'h0000_0200, 2'b01, 32'h55AA_00FF);
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("t6_mdr_cleared", 1, mdr_b, 32'h0);
        chk("t6_idle", 1, {31'b0, busy_b}, 32'd0);
        chk("t6_mdr_cleared", 0, mdr_a, 32'h0);
        repeat (5) tick;
        req(32'h0000_0202, 2'b10, 32'h55AA_00FF);
        wait_idle;
        chk("t6_fresh", 1, mdr_b, 32'h0000_55AA);
        chk("t6_fresh", 0, mdr_a, 32'h0000_55AA);

        repeat (3) tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdr_fetch_unit.md
Name: mdr_fetch_unit

Overview:
- Memory-read sequencer and Memory Data Register (MDR) for the multicycle datapath.
- On a control-unit read request it issues one read to the synchronous data memory and waits the fixed memory latency.
- It then right-aligns the addressed byte or halfword into bit 0 and holds the result as MDR_out, which directly feeds the load-size/extension stage.
- It also flags misaligned accesses without touching memory.

Parameters:
MEM_LATENCY, 1, cycles from the mem_rd cycle to the cycle mem_rdata is valid; must be >= 1 (0 illegal).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
rd_req  input  1  read request from control unit; sampled only in IDLE
rd_addr  input  32  byte address of the load
ls_size  input  2  access size: 01 word, 11 halfword, 10 byte, 00 illegal
busy  output  1  high whenever state != IDLE
mem_rd  output  1  one-cycle read strobe to data memory
mem_addr  output  32  word address to memory, {addr[31:2],2'b00}
mem_rdata  input  32  memory read data, little-endian lanes (byte k at [8k+7:8k])
MDR_out  output  32  aligned load data, held until next capture
mdr_valid  output  1  one-cycle pulse: MDR_out updated this cycle
align_err  output  1  one-cycle pulse: request rejected as misaligned/illegal

Behaviour:
- Reset (synchronous, any state): state=IDLE; MDR_out=0, mem_addr=0, mem_rd=0, mdr_valid=0, align_err=0, busy=0, wait counter=0. Reset mid-transaction aborts it; in-flight memory data is never captured and no mdr_valid or align_err follows.
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE, rd_req=0: stay in IDLE.
- IDLE, rd_req=1: latch rd_addr and ls_size. The request is illegal if ls_size=00, or word with addr[1:0]!=00, or halfword with addr[0]=1.
  - Illegal -> ERR.
  - Legal -> ISSUE.
- ERR (1 cycle): align_err=1, mem_rd stays 0, MDR_out unchanged; next state IDLE.
- ISSUE (1 cycle): mem_rd=1, mem_addr={latched addr[31:2],2'b00}; next state WAIT with counter=1.
- WAIT:
  - If counter==MEM_LATENCY: capture MDR_out <= mem_rdata >> (8*latched addr[1:0]), logical shift with zero fill; next state DONE.
  - Otherwise counter+1 and stay in WAIT.
  - Word reads always have shift 0.
- DONE (1 cycle): mdr_valid=1; next state IDLE.
- Latency: rd_req sampled in cycle T gives mem_rd in T+1, mem_rdata used in T+1+MEM_LATENCY, and mdr_valid/new MDR_out in T+2+MEM_LATENCY. Back-to-back reads therefore take MEM_LATENCY+3 cycles each.
- Upper bits: for byte/halfword, bits above the access size are not masked here beyond shift zero-fill; the downstream size stage performs final masking/extension.
- rd_req while busy (ISSUE, WAIT, DONE, ERR) is ignored and not queued. rd_addr/ls_size changes after acceptance have no effect.
- mem_addr holds its last value outside ISSUE. mem_rd is high only in ISSUE.
- MDR_out changes only on capture or reset.
- Counter width: clog2(MEM_LATENCY+1) bits; no wrap is possible.

Test Plan:
1. Reset, then word read (MEM_LATENCY=1): rd_req at T, rd_addr=0x0000_0010, ls_size=01, memory returns 0xDEADBEEF -> mem_rd=1 with mem_addr=0x10 at T+1; mdr_valid=1 and MDR_out=0xDEADBEEF at T+3; busy high T+1..T+3.
2. Byte lanes: ls_size=10, addr 0x23, mem_rdata=0x11223344 -> MDR_out=0x00000011, mem_addr=0x20. Repeat with addr 0x21 -> MDR_out=0x00112233.
3. Halfword at addr 0x42, mem_rdata=0xCAFE1234 -> MDR_out=0x0000CAFE. Halfword at 0x41 -> align_err pulse at T+1, mem_rd never asserted, MDR_out keeps its prior value.
4. Illegal cases: word at 0x06 -> align_err. ls_size=00 at 0x08 -> align_err. In both cases busy=1 for exactly one cycle and there is no mdr_valid.
5. MEM_LATENCY=3 build: word read -> mdr_valid at T+5. A second rd_req held high during T+1..T+5 is ignored, with exactly one mem_rd pulse. rd_req at T+6 is accepted.
6. Reset asserted in WAIT (MEM_LATENCY=3, cycle T+3) -> next cycle IDLE, MDR_out=0, no mdr_valid. A fresh read afterwards completes normally.
